// File: rtl/cpu_div_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_div_pkg
// Op-code encodings, issue FSM states and watchdog default for div_issue_ctrl.
// Revision : 1.0
// ============================================================================
package cpu_div_pkg;

  localparam int unsigned c_timeout_default = 63;

  localparam logic [2:0] c_op_divu = 3'd0;
  localparam logic [2:0] c_op_div  = 3'd1;
  localparam logic [2:0] c_op_mthi = 3'd2;
  localparam logic [2:0] c_op_mtlo = 3'd3;
  localparam logic [2:0] c_op_mfhi = 3'd4;
  localparam logic [2:0] c_op_mflo = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == c_op_divu) || (op == c_op_div);
  endfunction

  // Codes 6 and 7 are NOPs and never interact with HI/LO or the divider.
  function automatic logic is_real_op(input logic [2:0] op);
    return op <= c_op_mflo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Issues DIV/DIVU to an external iterative divider and owns HI/LO.
// Option   : DIV_ZERO_BYPASS_EN retires divide-by-zero without the divider.
// Revision : 1.0
// ============================================================================
module div_issue_ctrl
  import cpu_div_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_timeout_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        timeout_err
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  div_state_e         r_state;
  div_state_e         w_next;
  logic               r_abort;
  logic [c_cnt_w-1:0] r_cnt;

  logic w_div_op;
  logic w_zero_bypass;
  logic w_issue;
  logic w_res_wr;
  logic w_wait_done;
  logic w_timeout;

  assign w_div_op = op_valid && is_div_op(op_code);

`ifdef DIV_ZERO_BYPASS_EN
  assign w_zero_bypass = (rt_val == 32'd0);
`else
  assign w_zero_bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_res_wr    = 1'b0;
    w_wait_done = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_div_op && !flush && !w_zero_bypass) begin
          w_issue = 1'b1;
          w_next  = WAIT;
        end
      end
      WAIT: begin
        // A result arriving on the last watchdog cycle still wins.
        if (div_ready) begin
          w_wait_done = 1'b1;
          w_res_wr    = !r_abort && !flush;
          w_next      = RELEASE;
        end else if (r_cnt == c_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = RELEASE;
        end
      end
      RELEASE: begin
        if (!div_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase

    // An aborted divide no longer holds EX, but any later op that needs
    // HI/LO or the divider must wait for the unit to drain.
    stall = !rst && (w_issue
                     || ((r_state == WAIT) && !r_abort)
                     || ((r_state != IDLE) && op_valid && is_real_op(op_code)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_start   <= 1'b0;
      div_signed  <= 1'b0;
      div_a       <= 32'd0;
      div_b       <= 32'd0;
      r_abort     <= 1'b0;
      r_cnt       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (w_issue) begin
        div_a      <= rs_val;
        div_b      <= rt_val;
        div_signed <= op_code[0];
        div_start  <= 1'b1;
        r_abort    <= 1'b0;
        r_cnt      <= '0;
      end

      if (r_state == WAIT) begin
        if (flush) begin
          r_abort <= 1'b1;
        end
        if (w_wait_done || w_timeout) begin
          div_start <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_timeout) begin
          timeout_err <= 1'b1;
        end
      end

      if (w_res_wr) begin
        lo <= div_result[31:0];
        hi <= div_result[63:32];
      end else if ((r_state == IDLE) && op_valid && !flush) begin
        if (op_code == c_op_mthi) begin
          hi <= rs_val;
        end else if (op_code == c_op_mtlo) begin
          lo <= rs_val;
        end
      end
    end
  end

  assign mf_data = (op_code == c_op_mfhi) ? hi : lo;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// Bench for div_issue_ctrl: directed ops against a transaction-timed model
// and an in-bench fixed-latency divider.
module tb_div_issue_ctrl;
  import cpu_div_pkg::*;

  localparam int TO  = 8;
  localparam int LAT = 7;
  localparam int BIG = 1 << 30;

`ifdef DIV_ZERO_BYPASS_EN
  localparam logic [31:0] Z_HI    = 32'd0;
  localparam logic [31:0] Z_LO    = 32'd11;
  localparam logic        Z_ISSUE = 1'b0;
`else
  localparam logic [31:0] Z_HI    = 32'd5;
  localparam logic [31:0] Z_LO    = 32'hFFFF_FFFF;
  localparam logic        Z_ISSUE = 1'b1;
`endif

  logic        clk, rst, op_valid, flush, stall, div_start, div_signed, div_ready, timeout_err;
  logic [2:0]  op_code;
  logic [31:0] rs_val, rt_val, mf_data, hi, lo, div_a, div_b;
  logic [63:0] div_result;

  div_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
    .mf_data(mf_data), .hi(hi), .lo(lo), .div_start(div_start),
    .div_signed(div_signed), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_result(div_result), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Fixed-latency divider: ready in the LAT-th cycle of div_start, held
  // until div_start drops, then cleared one cycle later.
  logic       stub_never;
  logic [3:0] stub_cnt;
  logic       stub_ready;
  always_ff @(posedge clk) begin : div_model_stub
    if (rst || !div_start) begin
      stub_cnt   <= 4'd0;
      stub_ready <= 1'b0;
    end else if (!stub_never) begin
      if (stub_cnt == 4'(LAT - 2)) stub_ready <= 1'b1;
      else                         stub_cnt   <= stub_cnt + 4'd1;
    end
  end
  assign div_ready  = stub_ready;
  assign div_result = ref_div(div_a, div_b, div_signed);

  int n_chk, n_fail;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a divide issued in cycle t occupies the divider for cycles
  // t+1..t+LAT (or t+TO when it never answers); the unit is free again at
  // t+LAT+3 (ready falls one cycle after start drops) or t+TO+2.
  int          cyc, idle_at, t_issue, end_wait, killed_from;
  logic        have_div, psgn, m_to;
  logic [31:0] m_hi, m_lo, pa, pb;
  logic        m_idle, m_wait, m_issue, m_bypass;

  function automatic logic zero_bypass(input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
    return b == 32'd0;
`else
    return 1'b0 & b[0];
`endif
  endfunction

  always begin
    @(posedge clk);
    if (rst) begin
      idle_at = cyc + 1; have_div = 1'b0; killed_from = BIG;
      m_hi = 32'd0; m_lo = 32'd0; m_to = 1'b0;
    end else begin
      m_idle = cyc >= idle_at;
      m_wait = have_div && (cyc > t_issue) && (cyc <= end_wait);
      if (m_wait && flush && killed_from == BIG) killed_from = cyc + 1;
      if (m_wait && cyc == end_wait) begin
        if (stub_never)              m_to = 1'b1;
        else if (killed_from == BIG) {m_hi, m_lo} = ref_div(pa, pb, psgn);
      end
      if (m_idle && op_valid && !flush) begin
        if (op_code == c_op_mthi) m_hi = rs_val;
        else if (op_code == c_op_mtlo) m_lo = rs_val;
        else if (op_code <= c_op_div && !zero_bypass(rt_val)) begin
          t_issue = cyc; have_div = 1'b1; killed_from = BIG;
          pa = rs_val; pb = rt_val; psgn = op_code[0];
          end_wait = cyc + (stub_never ? TO : LAT);
          idle_at  = stub_never ? cyc + TO + 2 : cyc + LAT + 3;
        end
      end
    end
    cyc++;
  end

  int   stall_cnt;
  logic ds_seen, ds_after, prev_rdy_start;
  logic c_idle, c_wait, c_issue, c_real, e_stall;
  always begin
    @(negedge clk);
    if (!rst) begin
      c_idle  = cyc >= idle_at;
      c_wait  = have_div && (cyc > t_issue) && (cyc <= end_wait);
      c_real  = op_valid && (op_code <= c_op_mflo);
      c_issue = c_idle && op_valid && (op_code <= c_op_div) && !flush && !zero_bypass(rt_val);
      e_stall = c_issue || (c_wait && cyc < killed_from) || (!c_idle && c_real);
      chk("stall", {63'd0, stall}, {63'd0, e_stall});
      chk("div_start", {63'd0, div_start}, {63'd0, c_wait});
      if (c_wait) begin
        chk("div_a", {32'd0, div_a}, {32'd0, pa});
        chk("div_b", {32'd0, div_b}, {32'd0, pb});
        chk("div_signed", {63'd0, div_signed}, {63'd0, psgn});
      end
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
      chk("timeout_err", {63'd0, timeout_err}, {63'd0, m_to});
      if (op_code == c_op_mfhi) chk("mf_data_hi", {32'd0, mf_data}, {32'd0, m_hi});
      if (op_code == c_op_mflo) chk("mf_data_lo", {32'd0, mf_data}, {32'd0, m_lo});
      if (stall === 1'b1) stall_cnt++;
      if (div_start === 1'b1) ds_seen = 1'b1;
      if (prev_rdy_start) ds_after = div_start;
      prev_rdy_start = div_ready && div_start;
    end
  end

  task automatic set_in(input logic v, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic f);
    op_valid = v; op_code = c; rs_val = a; rt_val = b; flush = f;
  endtask

  task automatic op(input logic v, input logic [2:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic f);
    set_in(v, c, a, b, f);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) op(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; idle_at = 0; t_issue = 0; end_wait = 0;
    killed_from = BIG; have_div = 1'b0; psgn = 1'b0; pa = 32'd0; pb = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_to = 1'b0;
    stall_cnt = 0; ds_seen = 1'b0; ds_after = 1'b1; prev_rdy_start = 1'b0;
    stub_never = 1'b0;
    rst = 1'b1;
    set_in(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_div_start", {63'd0, div_start}, 64'd0);
    chk("rst_div_ab", {div_a, div_b}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
    rst = 1'b0;

    // DIVU 100/7: 8 stall cycles, then start drops right after ready
    stall_cnt = 0; ds_after = 1'b1;
    op(1'b1, c_op_divu, 32'd100, 32'd7, 1'b0);
    nop(12);
    chk("divu_lo", {32'd0, lo}, 64'd14);
    chk("divu_hi", {32'd0, hi}, 64'd2);
    chk("divu_stall_cycles", 64'(stall_cnt), 64'd8);
    chk("divu_start_after_ready", {63'd0, ds_after}, 64'd0);
    set_in(1'b1, c_op_mflo, 32'd0, 32'd0, 1'b0);
    #1;
    chk("mflo_literal", {32'd0, mf_data}, 64'd14);
    @(posedge clk);
    #1;

    // signed DIV -7/2
    op(1'b1, c_op_div, 32'hFFFF_FFF9, 32'd2, 1'b0);
    nop(12);
    chk("div_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    chk("div_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

    // MTHI held while the divider is busy
    op(1'b1, c_op_divu, 32'd50, 32'd5, 1'b0);
    nop(2);
    repeat (6) op(1'b1, c_op_mthi, 32'h1234, 32'd0, 1'b0);
    chk("mthi_not_early", {32'd0, hi}, 64'd0);
    op(1'b1, c_op_mthi, 32'h1234, 32'd0, 1'b0);
    set_in(1'b1, c_op_mthi, 32'h1234, 32'd0, 1'b0);
    #1;
    chk("mthi_idle_nostall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    chk("mthi_hi", {32'd0, hi}, 64'h1234);
    chk("mthi_lo", {32'd0, lo}, 64'd10);
    nop(1);

    // flush three cycles into WAIT
    op(1'b1, c_op_divu, 32'd1000, 32'd3, 1'b0);
    nop(2);
    op(1'b1, c_op_divu, 32'd1000, 32'd3, 1'b1);
    set_in(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    #1;
    chk("flush_stall_drop", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    repeat (6) op(1'b1, c_op_divu, 32'd77, 32'd7, 1'b0);
    chk("flush_hi_kept", {32'd0, hi}, 64'h1234);
    chk("flush_lo_kept", {32'd0, lo}, 64'd10);
    chk("reissue_start", {63'd0, div_start}, 64'd1);
    nop(12);
    chk("reissue_lo", {32'd0, lo}, 64'd11);
    chk("reissue_hi", {32'd0, hi}, 64'd0);

    // divide by zero
    ds_seen = 1'b0;
    op(1'b1, c_op_divu, 32'd5, 32'd0, 1'b0);
    nop(12);
    chk("divzero_issued", {63'd0, ds_seen}, {63'd0, Z_ISSUE});
    chk("divzero_hi", {32'd0, hi}, {32'd0, Z_HI});
    chk("divzero_lo", {32'd0, lo}, {32'd0, Z_LO});

    // watchdog: divider never answers
    stub_never = 1'b1;
    op(1'b1, c_op_divu, 32'd9, 32'd3, 1'b0);
    nop(12);
    stub_never = 1'b0;
    chk("timeout_flag", {63'd0, timeout_err}, 64'd1);
    chk("timeout_hi", {32'd0, hi}, {32'd0, Z_HI});
    set_in(1'b1, c_op_mtlo, 32'hABCD, 32'd0, 1'b0);
    #1;
    chk("timeout_idle_nostall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    chk("mtlo_lo", {32'd0, lo}, 64'hABCD);
    op(1'b1, c_op_mfhi, 32'd0, 32'd0, 1'b0);

    // flush in IDLE kills the same-cycle op
    ds_seen = 1'b0;
    op(1'b1, c_op_divu, 32'd8, 32'd2, 1'b1);
    op(1'b1, c_op_mthi, 32'd99, 32'd0, 1'b1);
    nop(3);
    chk("idle_flush_no_issue", {63'd0, ds_seen}, 64'd0);
    chk("idle_flush_hi", {32'd0, hi}, {32'd0, Z_HI});
    chk("idle_flush_lo", {32'd0, lo}, 64'hABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 63, meaning max cycles in WAIT before timeout.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port op_valid  input  1  EX-stage request valid.
REQ-005 SHALL have port op_code  input  3  0=DIVU, 1=DIV, 2=MTHI, 3=MTLO, 4=MFHI, 5=MFLO, others=NOP.
REQ-006 SHALL have port rs_val  input  32  dividend, or MTHI/MTLO source.
REQ-007 SHALL have port rt_val  input  32  divisor.
REQ-008 SHALL have port flush  input  1  pipeline kill of the in-flight op.
REQ-009 SHALL have port stall  output  1  hold EX stage.
REQ-010 SHALL have port mf_data  output  32  HI or LO for MFHI/MFLO, combinational.
REQ-011 SHALL have port hi, lo  output  32 each  architectural HI/LO registers.
REQ-012 SHALL have port div_start, div_signed  output  1 each  divider request and signedness.
REQ-013 SHALL have port div_a, div_b  output  32 each  operands, registered, stable while div_start=1.
REQ-014 SHALL have port div_ready  input  1  divider done.
REQ-015 SHALL have port div_result  input  64  {remainder[63:32], quotient[31:0]}.
REQ-016 SHALL have port timeout_err  output  1  sticky watchdog flag.

Function
REQ-017 SHALL use FSM states IDLE, WAIT, RELEASE.
REQ-018 SHALL, in IDLE, on op_valid with DIV/DIVU and no flush, latch operands and div_signed=op_code[0], raise div_start, and go to WAIT.
REQ-019 SHALL hold div_start=1 and operands constant throughout WAIT.
REQ-020 SHALL, in WAIT on div_ready=1, write lo<=div_result[31:0] and hi<=div_result[63:32] (unless aborted), drop div_start, and go to RELEASE.
REQ-021 SHALL stay in RELEASE until div_ready=0, then go to IDLE; a new divide SHALL NOT issue before then.
REQ-022 SHALL assert stall for a DIV/DIVU from the issue cycle until the cycle HI/LO are written, inclusive of the issue cycle; total latency = divider latency + 1.
REQ-023 SHALL assert stall for any op_valid MTHI/MTLO/MFHI/MFLO while state != IDLE.
REQ-024 SHALL, in IDLE, write MTHI/MTLO to hi/lo on the next edge without stall.
REQ-025 SHALL drive mf_data from the current hi/lo; MF in the same cycle as the HI/LO write SHALL be stalled one cycle.
REQ-026 SHALL, on flush in WAIT, set an abort flag, keep div_start high until div_ready, discard the result (hi/lo unchanged), and deassert stall immediately.
REQ-027 SHALL ignore flush in IDLE with the same-cycle op_valid (no issue, no write).
REQ-028 SHALL count cycles in WAIT; on reaching TIMEOUT_CYCLES, it SHALL set timeout_err, drop div_start, leave hi/lo unchanged, and go to RELEASE.

Reset
REQ-029 SHALL on rst set state=IDLE, hi=lo=0, div_start=0, div_signed=0, div_a=div_b=0, abort=0, counter=0, timeout_err=0, stall=0.
REQ-030 SHALL let rst mid-WAIT override everything in that cycle.

Configuration
REQ-031 SHALL, when DIV_ZERO_BYPASS_EN is defined, complete DIV/DIVU with rt_val=0 in one cycle without asserting div_start, with stall=0 and hi/lo unchanged.
REQ-032 SHALL, without DIV_ZERO_BYPASS_EN, issue divide-by-zero to the divider like any other divide.

Structure
REQ-033 SHALL place the op_code encodings, FSM state encodings and TIMEOUT_CYCLES default in shared package cpu_div_pkg.
REQ-034 SHALL be a single module; a behavioural divider model (div_model_stub, fixed 7-cycle latency) SHALL be used only in the bench.

Verification
REQ-035 SHALL test: DIVU 100/7 -> stall 8 cycles, lo=14, hi=2, div_start low in the cycle after div_ready.
REQ-036 SHALL test: DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 SHALL test: MTHI 0x1234 during WAIT -> stall until IDLE, then hi=0x1234 one cycle later.
REQ-038 SHALL test: flush 3 cycles into WAIT -> stall drops the next cycle, hi/lo keep prior values, and the next DIV issues only after div_ready=0.
REQ-039 SHALL test: with DIV_ZERO_BYPASS_EN, DIVU 5/0 -> div_start never asserted and hi/lo unchanged; without it, the op is issued.
REQ-040 SHALL test: divider stub never ready with TIMEOUT_CYCLES=8 -> timeout_err=1 after 8 WAIT cycles and FSM back to IDLE.
